// File: rtl/multi_tick_gen.sv
// rtl/multi_tick_gen.sv - multi-channel tick / square-wave generator with run-time divisors
// Optional macro PHASE_SYNC_EN adds sync_in to phase-align all channels.
module multi_tick_gen #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 32,
  parameter int CH_W   = 2,
  parameter logic [NUM_CH*CNT_W-1:0] DEFAULT_DIVS = {32'd200000, 32'd25000000, 32'd100000}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
`ifdef PHASE_SYNC_EN
  input  logic              sync_in,
`endif
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_a;
    logic [CNT_W-1:0] div_s;
    logic [CNT_W-1:0] div_new;
    logic             pend_q;
    logic             tick_q;
    logic             sq_q;
    logic             we_hit;
    logic             run;
    logic             wrap;

    // Out-of-range channel numbers never match any i, so those writes drop out here.
    assign we_hit  = cfg_we && (cfg_ch == CH_W'(i));
    assign run     = ch_en[i] && (div_a != '0);
    assign wrap    = (cnt == div_a - CNT_W'(1));
    assign div_new = we_hit ? cfg_div : div_s;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt    <= '0;
        div_a  <= DEFAULT_DIVS[i*CNT_W +: CNT_W];
        div_s  <= '0;
        pend_q <= 1'b0;
        tick_q <= 1'b0;
        sq_q   <= 1'b0;
      end
`ifdef PHASE_SYNC_EN
      else if (sync_in) begin
        cnt    <= '0;
        tick_q <= 1'b0;
        sq_q   <= 1'b0;
        pend_q <= 1'b0;
        if (we_hit || pend_q) div_a <= div_new;
        if (we_hit) div_s <= cfg_div;
      end
`endif
      else if (run) begin
        tick_q <= wrap;
        if (wrap) begin
          // Period boundary: the only point where a running channel adopts a new divisor.
          cnt  <= '0;
          sq_q <= ~sq_q;
          if (we_hit || pend_q) begin
            div_a  <= div_new;
            pend_q <= 1'b0;
          end
          if (we_hit) div_s <= cfg_div;
        end else begin
          cnt <= cnt + CNT_W'(1);
          if (we_hit) begin
            div_s  <= cfg_div;
            pend_q <= 1'b1;
          end
        end
      end else begin
        tick_q <= 1'b0;
        if (we_hit) begin
          div_s  <= cfg_div;
          pend_q <= 1'b1;
        end else if (pend_q) begin
          // Stopped channel has no boundary to wait for; restart so cnt stays below div.
          div_a  <= div_s;
          cnt    <= '0;
          pend_q <= 1'b0;
        end
      end
    end

    assign pending[i] = pend_q;
    assign tick[i]    = tick_q;
    assign sq[i]      = sq_q;
  end

endmodule

// File: tb/tb_multi_tick_gen.sv
// tb/tb_multi_tick_gen.sv - scoreboard bench for multi_tick_gen with defaults {ch0=8, ch1=4, ch2=1}
module tb_multi_tick_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  ch_en;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [31:0] cfg_div;
  logic [2:0]  pending;
  logic [2:0]  tick;
  logic [2:0]  sq;
`ifdef PHASE_SYNC_EN
  logic        sync_in;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int r;
  int q0[$];
  int q1[$];
  int q2[$];

  multi_tick_gen #(
    .NUM_CH(3),
    .CNT_W(32),
    .CH_W(2),
    .DEFAULT_DIVS({32'd1, 32'd4, 32'd8})
  ) dut (
    .clk(clk),
    .rst(rst),
    .ch_en(ch_en),
    .cfg_we(cfg_we),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
`ifdef PHASE_SYNC_EN
    .sync_in(sync_in),
`endif
    .pending(pending),
    .tick(tick),
    .sq(sq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int ch, input int t);
    case (ch)
      0: q0.push_back(t);
      1: q1.push_back(t);
      default: q2.push_back(t);
    endcase
  endtask

  // Monitor: every observed tick consumes the oldest expected tick time for its channel.
  always @(negedge clk) begin
    for (int c = 0; c < 3; c++) begin
      if (tick[c]) begin
        int e;
        bit have;
        have = 1'b0;
        e = 0;
        case (c)
          0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        checks++;
        if (!have) begin
          errors++;
          $display("FAIL unexpected_tick ch%0d at cycle %0d: got tick, expected none", c, cyc);
        end else if (e != cyc) begin
          errors++;
          $display("FAIL tick_time ch%0d: got cycle %0d expected cycle %0d", c, cyc, e);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic run_to(input int t);
    do @(negedge clk); while (cyc < t);
    #1;
  endtask

  task automatic wr(input int ch, input int d);
    cfg_we  = 1'b1;
    cfg_ch  = 2'(ch);
    cfg_div = d;
    step(1);
    cfg_we  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ch_en = 3'b000;
    cfg_we = 1'b0;
`ifdef PHASE_SYNC_EN
    sync_in = 1'b0;
`endif
    step(2);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_sq", 32'(sq), 0);
    chk("rst_pending", 32'(pending), 0);
    rst = 1'b0;
  endtask

  task automatic end_phase(input string name);
    chk({name, "_missing_ch0"}, q0.size(), 0);
    chk({name, "_missing_ch1"}, q1.size(), 0);
    chk({name, "_missing_ch2"}, q2.size(), 0);
    q0.delete();
    q1.delete();
    q2.delete();
  endtask

  initial begin
    cfg_ch = 2'd0;
    cfg_div = 32'd0;
    do_reset();

    // Defaults: ch2 every cycle, ch1 every 4, ch0 every 8; first enabled edge is r+1
    r = cyc;
    for (int k = 1; k <= 16; k++) push(2, r + k);
    for (int k = 4; k <= 16; k += 4) push(1, r + k);
    push(0, r + 8);
    push(0, r + 16);
    ch_en = 3'b111;
    run_to(r + 6);
    chk("p1_sq1_high", 32'(sq[1]), 1);
    run_to(r + 10);
    chk("p1_sq1_low", 32'(sq[1]), 0);
    chk("p1_sq0_high", 32'(sq[0]), 1);
    run_to(r + 16);
    end_phase("p1");

    // ch1 4 -> 6 written at count 1, then a write landing exactly on a wrap
    do_reset();
    r = cyc;
    push(1, r + 4);
    push(1, r + 10);
    push(1, r + 16);
    push(1, r + 19);
    push(1, r + 22);
    ch_en = 3'b010;
    run_to(r + 1);
    wr(1, 6);
    chk("p2_pending_set", 32'(pending), 32'b010);
    run_to(r + 3);
    chk("p2_pending_hold", 32'(pending[1]), 1);
    run_to(r + 4);
    chk("p2_pending_clr", 32'(pending[1]), 0);
    run_to(r + 15);
    wr(1, 3);
    chk("p2_wrap_write_no_pending", 32'(pending[1]), 0);
    run_to(r + 22);
    end_phase("p2");

    // ch0 disabled at count 3 for 10 cycles
    do_reset();
    r = cyc;
    push(0, r + 8);
    push(0, r + 26);
    push(0, r + 34);
    ch_en = 3'b001;
    run_to(r + 11);
    ch_en = 3'b000;
    run_to(r + 16);
    chk("p3_sq0_frozen_a", 32'(sq[0]), 1);
    run_to(r + 21);
    chk("p3_sq0_frozen_b", 32'(sq[0]), 1);
    ch_en = 3'b001;
    run_to(r + 26);
    chk("p3_sq0_after", 32'(sq[0]), 0);
    run_to(r + 34);
    end_phase("p3");

    // ch1 halted with div 0, then restarted with div 2
    do_reset();
    r = cyc;
    push(1, r + 4);
    push(1, r + 16);
    push(1, r + 18);
    push(1, r + 20);
    ch_en = 3'b010;
    wr(1, 0);
    chk("p4_pending_zero", 32'(pending[1]), 1);
    run_to(r + 12);
    chk("p4_sq1_frozen", 32'(sq[1]), 1);
    chk("p4_pending_applied", 32'(pending[1]), 0);
    wr(1, 2);
    chk("p4_pending_two", 32'(pending[1]), 1);
    run_to(r + 14);
    chk("p4_pending_next_cycle", 32'(pending[1]), 0);
    run_to(r + 16);
    chk("p4_sq1_t16", 32'(sq[1]), 0);
    run_to(r + 18);
    chk("p4_sq1_t18", 32'(sq[1]), 1);
    run_to(r + 20);
    end_phase("p4");

    // Write to channel 3 ignored; reset with pending[0] discards the update
    do_reset();
    r = cyc;
    push(1, r + 4);
    push(1, r + 8);
    push(0, r + 8);
    ch_en = 3'b011;
    run_to(r + 1);
    wr(3, 2);
    chk("p5_bad_ch_pending", 32'(pending), 0);
    run_to(r + 9);
    wr(0, 5);
    chk("p5_pending0", 32'(pending), 32'b001);
    do_reset();
    end_phase("p5a");
    r = cyc;
    push(1, r + 4);
    push(1, r + 8);
    push(0, r + 8);
    ch_en = 3'b011;
    run_to(r + 8);
    chk("p5_pending_after_rst", 32'(pending), 0);
    end_phase("p5b");

`ifdef PHASE_SYNC_EN
    // Sync at arbitrary counts realigns all channels
    do_reset();
    r = cyc;
    for (int k = 1; k <= 5; k++) push(2, r + k);
    for (int k = 7; k <= 14; k++) push(2, r + k);
    push(1, r + 4);
    push(1, r + 10);
    push(1, r + 14);
    push(0, r + 14);
    ch_en = 3'b111;
    run_to(r + 5);
    sync_in = 1'b1;
    step(1);
    sync_in = 1'b0;
    chk("p6_sync_sq", 32'(sq), 0);
    chk("p6_sync_tick", 32'(tick), 0);
    run_to(r + 14);
    end_phase("p6");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_tick_gen.md
Name: multi_tick_gen

Overview:
- Parametrised multi-channel tick/clock-enable generator.
- Replaces fixed divided clocks with per-channel single-cycle `tick` enables, plus a 50% square wave `sq` per channel.
- Each channel's divisor is loadable at run time through a write port. Updates are glitch-free.
- Sits at top level. Feeds display scan, LED blink, input sampling and game-timer logic, all of which stay in the `clk` domain.

Parameters:
- NUM_CH, 3, number of independent channels.
- CNT_W, 32, counter and divisor width in bits.
- CH_W, 2, width of cfg_ch. Must satisfy 2^CH_W >= NUM_CH.
- DEFAULT_DIVS, {32'd200000, 32'd25000000, 32'd100000}, packed NUM_CH*CNT_W reset divisors. Channel 0 occupies the LSBs.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- ch_en  in  NUM_CH  per-channel run enable.
- cfg_we  in  1  divisor write strobe, one cycle.
- cfg_ch  in  CH_W  target channel of the write.
- cfg_div  in  CNT_W  new divisor value.
- pending  out  NUM_CH  per-channel flag: divisor update waiting for the period boundary.
- tick  out  NUM_CH  one-cycle pulse every `div` enabled cycles.
- sq  out  NUM_CH  square wave; toggles on each tick, period 2*div.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. While rst=1:
  - all counters = 0, tick = 0, sq = 0, pending = 0;
  - active divisor[i] = DEFAULT_DIVS[i]; shadow divisor cleared.
  - rst mid-period discards any pending update.
- Per channel i, when ch_en[i]=1 and active div >= 1:
  - counter increments each cycle from 0 to div-1, then wraps to 0;
  - on the wrap cycle the registered tick[i] asserts in the following cycle for exactly one cycle, and sq[i] toggles in that same cycle;
  - first tick after reset appears at cycle div (counting the first enabled cycle as cycle 1).
- div = 1: tick[i] held high every enabled cycle; sq[i] toggles every cycle.
- div = 0: channel halted. Counter held at 0, tick = 0, sq holds its value.
- ch_en[i]=0: counter and sq hold, tick[i]=0. Re-enable resumes from the held count; no extra tick is produced.
- Config write (cfg_we=1) is always accepted; there is no backpressure.
  - If cfg_ch >= NUM_CH, the write is ignored.
  - Otherwise the shadow divisor is written and pending[cfg_ch] is set the next cycle.
- Update application:
  - At the channel's next wrap, the active divisor is loaded from the shadow, the counter restarts at 0 and pending clears. The period in progress completes with the old divisor.
  - If the channel is disabled or its active div = 0, the update applies on the next cycle instead.
- Simultaneous events:
  - Write on the same cycle as a wrap: the new value is applied at that wrap, and pending never asserts.
  - Second write while pending: the shadow is overwritten; last write wins.
  - Write to channel j does not affect the counter or phase of any other channel.
- Arithmetic: the counter compares against div-1 at CNT_W bits. div = 2^CNT_W-1 is legal. No overflow path exists, because the counter never exceeds div-1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro PHASE_SYNC_EN.
- Defined:
  - adds input sync_in (1 bit);
  - a cycle with sync_in=1 (and rst=0) zeroes all counters and forces sq = 0 on all channels the next cycle;
  - it suppresses tick in that cycle and applies all pending updates immediately;
  - sync_in coinciding with a cfg write uses the newly written value.
  - Purpose: phase-aligning the LED blink with game round start.
- Not defined: sync_in port absent; channels free-run from reset only.

Test Plan:
- Reset with DEFAULTS overridden to {8,4,1}, all ch_en=1 -> tick[2] high every cycle; tick[1] every 4 cycles, first at cycle 4; tick[0] every 8 cycles; sq[1] period 8.
- Ch1 div=4, write cfg_div=6 at count 1 -> pending[1]=1, next tick still 4 cycles after previous, following ticks every 6 cycles; pending[1] clears at the wrap.
- ch_en[0] dropped at count 3 for 10 cycles, then raised -> no tick while low; next tick 5 enabled cycles after re-enable (div=8); sq[0] unchanged while disabled.
- Write cfg_div=0 to ch1 -> tick[1] stays 0 and sq[1] frozen; then write 2 -> update applied next cycle, ticks every 2 cycles.
- Write with cfg_ch=3 (NUM_CH=3), plus rst asserted mid-period with pending[0]=1 -> no channel changes from the write; after rst, pending=0 and all divisors back to defaults.
- PHASE_SYNC_EN: pulse sync_in at arbitrary counts -> all sq=0, no tick that cycle, ch0/1/2 next ticks at cycles 8/4/1 after sync.
